// File: rtl/mult_pkg.sv
// Shared constants and the result record carried from the multiplier chain to the consumer.
package mult_pkg;

    localparam int MULT_W      = 16;
    localparam int MULT_STAGES = 4;
    localparam int MULT_TAG_W  = 4;

    typedef struct packed {
        logic [MULT_W-1:0]     product;
        logic [MULT_TAG_W-1:0] tag;
    } mult_result_t;

endpackage

// File: rtl/mult_result_fifo.sv
// Show-ahead result FIFO: the head entry is visible on pop_data whenever count is non-zero.
module mult_result_fifo
    import mult_pkg::*;
#(
    parameter int DEPTH = 8,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             push,
    input  mult_result_t     push_data,
    input  logic             pop,
    output mult_result_t     pop_data,
    output logic [CNT_W-1:0] count,
    output logic             full
);

    localparam int PTR_W = $clog2(DEPTH);

    mult_result_t     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             empty;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_pop  = pop && !empty;
    // A push into a full FIFO is only legal when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    assign pop_data = mem[rd_ptr];

endmodule

// File: rtl/mult_flow_ctrl.sv
// Credit-based issue into a non-stalling multiplier chain; results are buffered with valid/ready.
// Handshakes: a transfer happens on a rising edge where valid && ready; in_ready never looks at out_ready.
module mult_flow_ctrl
    import mult_pkg::*;
#(
    parameter int STAGES = MULT_STAGES,
    parameter int DEPTH  = 8,
    parameter int TAG_W  = MULT_TAG_W  // must match the tag width of mult_result_t
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [MULT_W-1:0] in_a,
    input  logic [MULT_W-1:0] in_b,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              pipe_start,
    output logic [MULT_W-1:0] pipe_mcand,
    output logic [MULT_W-1:0] pipe_mplier,
    output logic [MULT_W-1:0] pipe_product,
    input  logic              pipe_done,
    input  logic [MULT_W-1:0] pipe_result,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [MULT_W-1:0] out_product,
    output logic [TAG_W-1:0]  out_tag,
    output logic              overflow_err
);

    localparam int CNT_W   = $clog2(DEPTH) + 1;
    localparam int SUM_W   = CNT_W + 1;
    localparam int BLANK_W = $clog2(STAGES + 1);

    logic [BLANK_W-1:0] blank_cnt;
    logic               blanking;
    logic [CNT_W-1:0]   in_flight;
    logic [CNT_W-1:0]   fifo_cnt;
    logic               fifo_full;
    logic [SUM_W-1:0]   credit_sum;
    logic [TAG_W-1:0]   issue_tag;
    logic [TAG_W-1:0]   tag_dly [STAGES];
    logic               accept;
    logic               capture;
    logic               retire;
    logic               pop;
    logic               push;
    mult_result_t       push_data;
    mult_result_t       pop_data;

    // Stages reset synchronously, so their done outputs are untrusted until STAGES edges have passed.
    assign blanking   = (blank_cnt != BLANK_W'(STAGES));
    assign credit_sum = SUM_W'(in_flight) + SUM_W'(fifo_cnt);
    assign in_ready   = (credit_sum < SUM_W'(DEPTH)) && !blanking;
    assign accept     = in_valid && in_ready;
    assign capture    = pipe_done && !blanking;
    assign retire     = capture && (in_flight != '0);
    assign out_valid  = (fifo_cnt != '0);
    assign pop        = out_valid && out_ready;
    assign push       = capture && (!fifo_full || pop);

    assign pipe_product = '0;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            blank_cnt    <= '0;
            in_flight    <= '0;
            overflow_err <= 1'b0;
        end else begin
            if (blanking) blank_cnt <= blank_cnt + BLANK_W'(1);
            case ({accept, retire})
                2'b10:   in_flight <= in_flight + CNT_W'(1);
                2'b01:   in_flight <= in_flight - CNT_W'(1);
                default: ;
            endcase
            if (capture && fifo_full && !pop) overflow_err <= 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pipe_start  <= 1'b0;
            pipe_mcand  <= '0;
            pipe_mplier <= '0;
            issue_tag   <= '0;
        end else begin
            pipe_start <= accept;
            if (accept) begin
                pipe_mcand  <= in_a;
                pipe_mplier <= in_b;
                issue_tag   <= in_tag;
            end
        end
    end

    // Free-running shift so the tag emerges in the same cycle as pipe_done.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < STAGES; i++) tag_dly[i] <= '0;
        end else begin
            tag_dly[0] <= issue_tag;
            for (int i = 1; i < STAGES; i++) tag_dly[i] <= tag_dly[i-1];
        end
    end

    assign push_data = '{product: pipe_result, tag: tag_dly[STAGES-1]};

    mult_result_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .pop_data  (pop_data),
        .count     (fifo_cnt),
        .full      (fifo_full)
    );

    assign out_product = pop_data.product;
    assign out_tag     = pop_data.tag;

endmodule
